// File: rtl/tone_window_detector.sv
// Windowed L1 tone detector: sums |re|+|im| over N_TONES bin windows per FFT frame,
// picks the strongest window against a threshold and reports it once it persists CONFIRM frames.
module tone_window_detector #(
  parameter int FFT_LEN      = 2048,
  parameter int N_TONES      = 4,
  parameter int TONE_BIN0    = 100,
  parameter int TONE_SPACING = 64,
  parameter int TONE_WIDTH   = 8,
  parameter int CONFIRM      = 3,
  localparam int ACC_W = 17 + $clog2(TONE_WIDTH),
  localparam int TID_W = $clog2(N_TONES + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in_n,
  input  logic             start_in,
  input  logic [31:0]      recording_length,
  input  logic [ACC_W-1:0] threshold_in,
  input  logic             fft_valid_in,
  input  logic             fft_last_in,
  input  logic [31:0]      fft_data_in,
  output logic             fft_ready_out,
  output logic [TID_W-1:0] tone_ident_out,
  output logic             tone_valid_out,
  input  logic             tone_ready_in,
  output logic             frame_err_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam int BIN_W = $clog2(FFT_LEN);
  localparam int RUN_W = $clog2(CONFIRM + 1);
  localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(FFT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_RESYNC,
    S_DECIDE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [ACC_W-1:0]   acc_q [N_TONES];
  logic [ACC_W-1:0]   acc_d [N_TONES];
  logic [31:0]        frames_q, frames_d;
  logic [31:0]        len_q, len_d;
  logic [ACC_W-1:0]   thr_q, thr_d;
  logic [TID_W-1:0]   prev_q, prev_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [TID_W-1:0]   rep_q, rep_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic [TID_W-1:0]   ident_q, ident_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               beat;
  logic signed [15:0] re_s, im_s;
  logic [16:0]        mag;
  logic [TID_W-1:0]   best_k;
  logic [ACC_W-1:0]   best_v;
  logic [TID_W-1:0]   cand;

  // |v| for a 16-bit two's complement value; 17 bits so |-32768| is exact.
  function automatic logic [16:0] abs17(input logic signed [15:0] v);
    logic signed [16:0] w;
    w = 17'(v);
    return w[16] ? unsigned'(-w) : unsigned'(w);
  endfunction

  function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] r);
    return (r >= RUN_W'(CONFIRM)) ? r : r + RUN_W'(1);
  endfunction

  // k is 0-based here: window k covers TONE_BIN0 + k*TONE_SPACING for TONE_WIDTH bins.
  function automatic logic in_window(input logic [BIN_W-1:0] bin, input int k);
    int lo;
    int b;
    lo = TONE_BIN0 + k * TONE_SPACING;
    b  = int'(bin);
    return (b >= lo) && (b < lo + TONE_WIDTH);
  endfunction

  assign beat = fft_valid_in && ready_q;
  assign re_s = fft_data_in[31:16];
  assign im_s = fft_data_in[15:0];
  assign mag  = abs17(re_s) + abs17(im_s);

  // Strict '>' keeps the lowest window on ties.
  always_comb begin
    best_k = TID_W'(1);
    best_v = acc_q[0];
    for (int k = 1; k < N_TONES; k++) begin
      if (acc_q[k] > best_v) begin
        best_v = acc_q[k];
        best_k = TID_W'(k + 1);
      end
    end
    cand = (best_v >= thr_q) ? best_k : '0;
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    acc_d    = acc_q;
    frames_d = frames_q;
    len_d    = len_q;
    thr_d    = thr_q;
    prev_d   = prev_q;
    run_d    = run_q;
    rep_d    = rep_q;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          len_d    = recording_length;
          thr_d    = threshold_in;
          frames_d = '0;
          prev_d   = '0;
          run_d    = '0;
          rep_d    = '0;
          bin_d    = '0;
          for (int k = 0; k < N_TONES; k++) acc_d[k] = '0;
          state_d  = (recording_length == 32'd0) ? S_DONE : S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (beat) begin
          for (int k = 0; k < N_TONES; k++) begin
            if (in_window(bin_q, k)) acc_d[k] = acc_q[k] + ACC_W'(mag);
          end
          bin_d = bin_q + BIN_W'(1);
          if (fft_last_in && (bin_q == BIN_LAST)) begin
            bin_d   = '0;
            state_d = S_DECIDE;
          end else if (fft_last_in || (bin_q == BIN_LAST)) begin
            // Bad frame length: drop the partial frame but keep the persistence history.
            err_d = 1'b1;
            bin_d = '0;
            for (int k = 0; k < N_TONES; k++) acc_d[k] = '0;
            state_d = fft_last_in ? S_ACCUM : S_RESYNC;
          end
        end
      end

      S_RESYNC: begin
        if (beat && fft_last_in) state_d = S_ACCUM;
      end

      S_DECIDE: begin
        frames_d = frames_q + 32'd1;
        for (int k = 0; k < N_TONES; k++) acc_d[k] = '0;
        if (cand == prev_q) begin
          run_d = sat_inc(run_q);
        end else begin
          run_d  = RUN_W'(1);
          prev_d = cand;
        end
        if ((run_d == RUN_W'(CONFIRM)) && (cand != rep_q)) begin
          rep_d   = cand;
          state_d = S_EMIT;
        end else if (frames_d == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ACCUM;
        end
      end

      S_EMIT: begin
        if (tone_ready_in) state_d = (frames_q == len_q) ? S_DONE : S_ACCUM;
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    ready_d = (state_d == S_ACCUM) || (state_d == S_RESYNC);
    valid_d = (state_d == S_EMIT);
    ident_d = (state_d == S_EMIT) ? rep_d : '0;
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q  <= S_IDLE;
      bin_q    <= '0;
      for (int k = 0; k < N_TONES; k++) acc_q[k] <= '0;
      frames_q <= '0;
      len_q    <= '0;
      thr_q    <= '0;
      prev_q   <= '0;
      run_q    <= '0;
      rep_q    <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      ident_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      acc_q    <= acc_d;
      frames_q <= frames_d;
      len_q    <= len_d;
      thr_q    <= thr_d;
      prev_q   <= prev_d;
      run_q    <= run_d;
      rep_q    <= rep_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      ident_q  <= ident_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign fft_ready_out  = ready_q;
  assign tone_valid_out = valid_q;
  assign tone_ident_out = ident_q;
  assign frame_err_out  = err_q;
  assign done_out       = done_q;
  assign busy_out       = busy_q;

endmodule

// File: tb/tb_tone_window_detector.sv
// Bench for tone_window_detector: directed scenarios plus randomized frames checked
// against a frame-level reference model of the window/threshold/persistence rules.
module tb_tone_window_detector;

  localparam int FFT_LEN      = 2048;
  localparam int N_TONES      = 4;
  localparam int TONE_BIN0    = 100;
  localparam int TONE_SPACING = 64;
  localparam int TONE_WIDTH   = 8;
  localparam int CONFIRM      = 3;
  localparam int ACC_W        = 17 + $clog2(TONE_WIDTH);
  localparam int TID_W        = $clog2(N_TONES + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      rec_len = '0;
  logic [ACC_W-1:0] thr_in = '0;
  logic             fft_valid = 1'b0;
  logic             fft_last = 1'b0;
  logic [31:0]      fft_data = '0;
  logic             fft_ready_out;
  logic [TID_W-1:0] tone_ident_out;
  logic             tone_valid_out;
  logic             tone_ready = 1'b0;
  logic             frame_err_out;
  logic             busy_out;
  logic             done_out;

  always #5 clk = ~clk;

  tone_window_detector #(
    .FFT_LEN(FFT_LEN), .N_TONES(N_TONES), .TONE_BIN0(TONE_BIN0),
    .TONE_SPACING(TONE_SPACING), .TONE_WIDTH(TONE_WIDTH), .CONFIRM(CONFIRM)
  ) dut (
    .clk_in(clk), .rst_in_n(rst_n), .start_in(start), .recording_length(rec_len),
    .threshold_in(thr_in), .fft_valid_in(fft_valid), .fft_last_in(fft_last),
    .fft_data_in(fft_data), .fft_ready_out(fft_ready_out), .tone_ident_out(tone_ident_out),
    .tone_valid_out(tone_valid_out), .tone_ready_in(tone_ready), .frame_err_out(frame_err_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] frame_mem [FFT_LEN];
  bit gaps_en = 1'b0;

  int m_prev, m_run, m_rep, m_frames, m_len, m_thr;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time exceeded, required completion earlier");
    $fatal(1, "watchdog expired");
  end

  function automatic int mag_of(input logic [31:0] w);
    logic signed [15:0] r;
    logic signed [15:0] i;
    int a;
    int b;
    r = w[31:16];
    i = w[15:0];
    a = r;
    b = i;
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    return a + b;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < FFT_LEN; i++) frame_mem[i] = '0;
  endtask

  // Frame-level reference: window energies, strongest window, persistence count.
  task automatic model_frame(output bit rep_v, output int rep_id, output bit done_v);
    longint e [N_TONES + 1];
    int best;
    int cand;
    for (int k = 1; k <= N_TONES; k++) begin
      e[k] = 0;
      for (int b = 0; b < TONE_WIDTH; b++)
        e[k] += mag_of(frame_mem[TONE_BIN0 + (k - 1) * TONE_SPACING + b]);
    end
    best = 1;
    for (int k = 2; k <= N_TONES; k++) if (e[k] > e[best]) best = k;
    cand = (e[best] >= longint'(m_thr)) ? best : 0;
    if (cand == m_prev) m_run = (m_run < CONFIRM) ? m_run + 1 : CONFIRM;
    else begin
      m_run  = 1;
      m_prev = cand;
    end
    m_frames++;
    rep_v  = (m_run == CONFIRM) && (cand != m_rep);
    if (rep_v) m_rep = cand;
    rep_id = cand;
    done_v = (m_frames == m_len);
  endtask

  task automatic send_frame(input int nbeats, input int last_at);
    for (int i = 0; i < nbeats; i++) begin
      int w;
      w = 0;
      if (gaps_en) begin
        while ($urandom_range(7) == 0) begin
          @(negedge clk);
          fft_valid = 1'b0;
          fft_last  = 1'b0;
        end
      end
      @(negedge clk);
      fft_valid = 1'b1;
      fft_data  = frame_mem[i % FFT_LEN];
      fft_last  = (i == last_at);
      while (!fft_ready_out) begin
        w++;
        if (w > 200) begin
          $display("FAIL stream_ready: ready=0 for %0d cycles at beat %0d, required 1", w, i);
          $fatal(1, "stream stalled");
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic do_start(input int len, input int thr);
    @(negedge clk);
    start   = 1'b1;
    rec_len = 32'(len);
    thr_in  = ACC_W'(thr);
    @(negedge clk);
    start    = 1'b0;
    m_prev   = 0;
    m_run    = 0;
    m_rep    = 0;
    m_frames = 0;
    m_len    = len;
    m_thr    = thr;
    n_checks++;
    if (busy_out !== 1'b1 || fft_ready_out !== 1'b1)
      $display("FAIL start: busy=%b ready=%b, required 1 1", busy_out, fft_ready_out);
    else n_pass++;
  endtask

  // Checks the DECIDE gap, report timing/hold/accept, and the follow-on state.
  task automatic post_frame(input bit exp_rep, input int exp_id, input bit exp_done, input int hold);
    @(negedge clk);
    fft_valid = 1'b0;
    fft_last  = 1'b0;
    n_checks++;
    if (fft_ready_out !== 1'b0 || tone_valid_out !== 1'b0)
      $display("FAIL decide_gap: ready=%b valid=%b, required 0 0", fft_ready_out, tone_valid_out);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (tone_valid_out !== exp_rep)
      $display("FAIL report_valid: valid=%b, required %b", tone_valid_out, exp_rep);
    else n_pass++;
    if (exp_rep) begin
      n_checks++;
      if (tone_ident_out !== TID_W'(exp_id))
        $display("FAIL report_id: id=%0d, required %0d", tone_ident_out, exp_id);
      else n_pass++;
      for (int c = 0; c < hold; c++) begin
        start   = (c == 5);
        rec_len = 32'd1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (tone_valid_out !== 1'b1 || tone_ident_out !== TID_W'(exp_id) || fft_ready_out !== 1'b0)
          $display("FAIL report_hold: valid=%b id=%0d ready=%b, required 1 %0d 0",
                   tone_valid_out, tone_ident_out, fft_ready_out, exp_id);
        else n_pass++;
      end
      tone_ready = 1'b1;
      @(negedge clk);
      tone_ready = 1'b0;
      n_checks++;
      if (tone_valid_out !== 1'b0)
        $display("FAIL report_drop: valid=%b after accept, required 0", tone_valid_out);
      else n_pass++;
    end
    n_checks++;
    if (done_out !== exp_done || fft_ready_out !== !exp_done)
      $display("FAIL after_frame: done=%b ready=%b, required %b %b",
               done_out, fft_ready_out, exp_done, !exp_done);
    else n_pass++;
    if (exp_done) begin
      @(negedge clk);
      n_checks++;
      if (done_out !== 1'b0 || busy_out !== 1'b0)
        $display("FAIL done_pulse: done=%b busy=%b a cycle later, required 0 0", done_out, busy_out);
      else n_pass++;
    end
  endtask

  task automatic run_frame(input int hold);
    bit rv;
    bit dv;
    int id;
    model_frame(rv, id, dv);
    send_frame(FFT_LEN, FFT_LEN - 1);
    post_frame(rv, id, dv, hold);
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if ({tone_valid_out, tone_ident_out, fft_ready_out, busy_out, done_out, frame_err_out} !== '0)
      $display("FAIL %s: valid=%b id=%0d ready=%b busy=%b done=%b err=%b, required all 0",
               tag, tone_valid_out, tone_ident_out, fft_ready_out, busy_out, done_out, frame_err_out);
    else n_pass++;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_zero_length();
    @(negedge clk);
    start   = 1'b1;
    rec_len = 32'd0;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (done_out !== 1'b1 || busy_out !== 1'b1 || fft_ready_out !== 1'b0)
      $display("FAIL zero_len: done=%b busy=%b ready=%b, required 1 1 0", done_out, busy_out, fft_ready_out);
    else n_pass++;
    @(negedge clk);
    check_all_zero("zero_len_idle");
  endtask

  task automatic test_tone_detect();
    clear_mem();
    frame_mem[164] = 32'h03E8_FE0C;
    do_start(5, 1000);
    for (int f = 0; f < 5; f++) run_frame(0);
  endtask

  task automatic test_threshold();
    clear_mem();
    frame_mem[164] = 32'h03E8_FE0C;
    do_start(5, 2000);
    for (int f = 0; f < 5; f++) run_frame(0);
  endtask

  task automatic test_tie_and_silence();
    clear_mem();
    frame_mem[100] = 32'h7FFF_0000;
    frame_mem[228] = 32'h7FFF_0000;
    do_start(6, 1000);
    for (int f = 0; f < 3; f++) run_frame(0);
    clear_mem();
    for (int f = 0; f < 3; f++) run_frame(0);
  endtask

  task automatic test_back_pressure();
    clear_mem();
    frame_mem[164] = 32'h03E8_FE0C;
    do_start(4, 1000);
    run_frame(0);
    run_frame(0);
    run_frame(20);
    run_frame(0);
  endtask

  task automatic check_err(input string tag, input bit exp_ready);
    @(negedge clk);
    fft_valid = 1'b0;
    fft_last  = 1'b0;
    n_checks++;
    if (frame_err_out !== 1'b1 || fft_ready_out !== exp_ready)
      $display("FAIL %s: err=%b ready=%b, required 1 %b", tag, frame_err_out, fft_ready_out, exp_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (frame_err_out !== 1'b0)
      $display("FAIL %s_pulse: err=%b a cycle later, required 0", tag, frame_err_out);
    else n_pass++;
  endtask

  task automatic test_frame_errors();
    clear_mem();
    frame_mem[164] = 32'h03E8_FE0C;
    do_start(3, 1000);
    run_frame(0);
    frame_mem[100] = 32'h7FFF_7FFF;
    send_frame(1001, 1000);
    check_err("early_last", 1'b1);
    frame_mem[100] = 32'h0;
    run_frame(0);
    frame_mem[100] = 32'h7FFF_7FFF;
    send_frame(FFT_LEN, -1);
    check_err("missing_last", 1'b1);
    send_frame(120, 119);
    @(negedge clk);
    fft_valid = 1'b0;
    fft_last  = 1'b0;
    n_checks++;
    if (fft_ready_out !== 1'b1 || frame_err_out !== 1'b0)
      $display("FAIL resync_exit: ready=%b err=%b, required 1 0", fft_ready_out, frame_err_out);
    else n_pass++;
    frame_mem[100] = 32'h0;
    run_frame(0);
  endtask

  task automatic test_reset_abort();
    bit rv;
    bit dv;
    int id;
    clear_mem();
    frame_mem[164] = 32'h03E8_FE0C;
    do_start(5, 1000);
    run_frame(0);
    run_frame(0);
    model_frame(rv, id, dv);
    send_frame(FFT_LEN, FFT_LEN - 1);
    @(negedge clk);
    fft_valid = 1'b0;
    fft_last  = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tone_valid_out !== rv)
      $display("FAIL pending_report: valid=%b, required %b", tone_valid_out, rv);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_abort");
    @(negedge clk);
    rst_n = 1'b1;
    do_start(1, 1000);
    run_frame(0);
  endtask

  task automatic test_random();
    int t;
    int thr;
    gaps_en = 1'b1;
    thr = int'($urandom_range(3000, 500));
    t = 2;
    do_start(6, thr);
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(9) < 3) t = int'($urandom_range(4, 0));
      for (int i = 0; i < FFT_LEN; i++) frame_mem[i] = $urandom;
      for (int k = 1; k <= N_TONES; k++) begin
        for (int b = 0; b < TONE_WIDTH; b++) begin
          int r;
          int q;
          if (k == t) begin
            r = int'($urandom_range(2000, 100));
            q = int'($urandom_range(2000, 100));
          end else begin
            r = int'($urandom_range(150, 0));
            q = int'($urandom_range(150, 0));
          end
          if ($urandom_range(1) == 1) r = -r;
          if ($urandom_range(1) == 1) q = -q;
          frame_mem[TONE_BIN0 + (k - 1) * TONE_SPACING + b] = {16'(r), 16'(q)};
        end
      end
      if (t != 0 && $urandom_range(3) == 0)
        frame_mem[TONE_BIN0 + (t - 1) * TONE_SPACING] = 32'h8000_8000;
      run_frame(int'($urandom_range(3, 0)));
    end
    gaps_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_length();
    test_tone_detect();
    test_threshold();
    test_tie_and_silence();
    test_back_pressure();
    test_frame_errors();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
